// File: rtl/bsg_cgol_ctrl.sv
// ----------------------------------------------------------------------------
// bsg_cgol_ctrl
//
// Sequencing controller for the Game of Life cell array. It accepts a new
// game (generation count; the board itself travels on the datapath bus),
// pulses the array load strobe for one cycle, then enables the array for
// exactly the requested number of generations. After that it presents the
// finished board as valid until the consumer takes it.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   v_i          new game valid (game_len_i stable while v_i)
//   game_len_i   generations to simulate, 0..max_game_length_p
//                (larger values saturate to max_game_length_p)
//   ready_o      controller accepts a new game
//   update_o     common update_i of all cells: load board value
//   en_o         common en_i of all cells: advance one generation
//   v_o          result board valid on the cell outputs
//   yumi_i       consumer accepts result (ignored while v_o=0)
//   frame_cnt_o  generations completed in the current game
//   pause_i      (only with BSG_CGOL_CTRL_PAUSE_EN) hold the run in place
//
// Build option:
//   BSG_CGOL_CTRL_PAUSE_EN  adds pause_i. While in RUN, pause_i=1 drops en_o
//                           and freezes the generation counter and state, so
//                           the generation count stays exact across pauses.
//                           No effect in IDLE, LOAD or DONE.
// ----------------------------------------------------------------------------
module bsg_cgol_ctrl #(
  parameter  int max_game_length_p = 1000,
  localparam int lg_w              = $clog2(max_game_length_p + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            v_i,
  input  logic [lg_w-1:0] game_len_i,
  output logic            ready_o,
  output logic            update_o,
  output logic            en_o,
  output logic            v_o,
  input  logic            yumi_i,
`ifdef BSG_CGOL_CTRL_PAUSE_EN
  input  logic            pause_i,
`endif
  output logic [lg_w-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [lg_w-1:0] max_len_lp = lg_w'(max_game_length_p);
  localparam logic [lg_w-1:0] one_lp     = lg_w'(1);
  localparam logic [lg_w-1:0] zero_lp    = '0;

  state_e          state_reg;
  logic [lg_w-1:0] len_reg;
  logic [lg_w-1:0] cnt_reg;
  logic [lg_w-1:0] cnt_inc;
  logic [lg_w-1:0] len_sat;
  logic            ready_reg;
  logic            update_reg;
  logic            en_reg;
  logic            v_reg;
  logic            run_adv;

  assign cnt_inc = cnt_reg + one_lp;

  // Out-of-range lengths are clamped so a bad request can never run past
  // the counter range or the board's intended maximum.
  assign len_sat = (game_len_i > max_len_lp) ? max_len_lp : game_len_i;

`ifdef BSG_CGOL_CTRL_PAUSE_EN
  // The pause gates the enable in the same cycle it freezes the counter, so
  // every en_o cycle seen by the array is matched by exactly one count.
  assign run_adv = ~pause_i;
  assign en_o    = en_reg & ~pause_i;
`else
  assign run_adv = 1'b1;
  assign en_o    = en_reg;
`endif

  assign ready_o     = ready_reg;
  assign update_o    = update_reg;
  assign v_o         = v_reg;
  assign frame_cnt_o = cnt_reg;

  // Single state machine; every output flop is loaded with the decode of the
  // state being entered, so the outputs are Moore and glitch-free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg  <= IDLE;
      len_reg    <= zero_lp;
      cnt_reg    <= zero_lp;
      ready_reg  <= 1'b1;
      update_reg <= 1'b0;
      en_reg     <= 1'b0;
      v_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (v_i && ready_reg) begin
            len_reg    <= len_sat;
            cnt_reg    <= zero_lp;
            state_reg  <= LOAD;
            ready_reg  <= 1'b0;
            update_reg <= 1'b1;
          end
        end

        LOAD: begin
          update_reg <= 1'b0;
          if (len_reg != zero_lp) begin
            state_reg <= RUN;
            en_reg    <= 1'b1;
          end else begin
            state_reg <= DONE;
            v_reg     <= 1'b1;
          end
        end

        RUN: begin
          if (run_adv) begin
            cnt_reg <= cnt_inc;
            // Leaving after the len_reg-th enabled cycle.
            if (cnt_inc == len_reg) begin
              state_reg <= DONE;
              en_reg    <= 1'b0;
              v_reg     <= 1'b1;
            end
          end
        end

        DONE: begin
          // ready returns only in the cycle after yumi, so a game can never
          // be accepted on the same edge that retires the previous result.
          if (yumi_i) begin
            state_reg <= IDLE;
            v_reg     <= 1'b0;
            ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg  <= IDLE;
          ready_reg  <= 1'b1;
          update_reg <= 1'b0;
          en_reg     <= 1'b0;
          v_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bsg_cgol_ctrl.md
Name: bsg_cgol_ctrl

Overview:
Sequencing controller for the Game of Life cell array.
- Accepts a new game (initial board plus generation count) over a valid/ready handshake.
- Pulses the array load strobe, then asserts the array step enable for exactly the requested number of generations.
- Presents the finished board as valid and holds it until the consumer accepts it over a valid/yumi handshake.
- Sits between the board input/output adapters and the cell array. It drives the array's update_i and en_i in common to all cells. Board data bypasses this block.

Parameters:
max_game_length_p, 1000, maximum number of generations per game; count width lg_w = $clog2(max_game_length_p+1)

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
v_i  input  1  new game valid (board on datapath bus, game_len_i stable while v_i)
game_len_i  input  lg_w  generations to simulate, 0..max_game_length_p
ready_o  output  1  controller accepts a new game
update_o  output  1  to all cells' update_i: load board value
en_o  output  1  to all cells' en_i: advance one generation
v_o  output  1  result board valid on cell outputs
yumi_i  input  1  consumer accepts result (legal only while v_o=1)
frame_cnt_o  output  lg_w  generations completed in current game

Behaviour:
- Clock and reset: one clock clk_i. reset_i is synchronous, active-high, sampled on posedge clk_i.
- Reset state:
  - state=IDLE, counter=0.
  - ready_o=1, update_o=0, en_o=0, v_o=0, frame_cnt_o=0.
- Reset mid-operation: same result from any state. Abandons the game, no v_o pulse, board contents don't matter.
- State register is 2 bits. States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On v_i&ready_o: latch len_r=game_len_i, clear counter, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - update_o=1, en_o=0, ready_o=0.
  - Next state: RUN if len_r!=0, else DONE.
- RUN:
  - en_o=1 every cycle, counter increments each cycle.
  - When counter+1==len_r, go to DONE.
  - en_o is high for exactly len_r consecutive cycles.
- DONE:
  - v_o=1, en_o=0, update_o=0, ready_o=0.
  - On yumi_i go to IDLE.
  - No new game is accepted on the yumi cycle; ready_o returns the following cycle.
- Timing, for handshake at edge T:
  - update_o is high in cycle T+1.
  - en_o is high in cycles T+2 .. T+1+N.
  - v_o rises at T+2+N, or T+2 when N=0.
- Mutual exclusion: update_o and en_o are never both 1. Both outputs are registered-state decodes (Moore); neither depends combinationally on v_i or yumi_i.
- frame_cnt_o:
  - Equals the counter and is always <= len_r.
  - Holds len_r in DONE.
  - Cleared on acceptance of the next game.
- game_len_i > max_game_length_p is illegal. Saturate len_r to max_game_length_p.
- yumi_i while v_o=0 is ignored. v_i outside IDLE is ignored and does not corrupt len_r.

Optional Feature:
Macro BSG_CGOL_CTRL_PAUSE_EN.
- When defined:
  - Adds input pause_i (1 bit).
  - In RUN, pause_i=1 forces en_o=0 and freezes the counter and state.
  - Generation count stays exact across pauses.
  - pause_i has no effect in IDLE, LOAD or DONE.
- When undefined:
  - No pause_i port.
  - RUN asserts en_o unconditionally.

Test Plan:
1. Reset: reset_i=1 for 2 cycles from arbitrary state -> ready_o=1, update_o=0, en_o=0, v_o=0, frame_cnt_o=0.
2. Nominal game:
   - Stimulus: v_i=1, game_len_i=5 at edge T.
   - Required: update_o=1 only at T+1; en_o=1 exactly cycles T+2..T+6; v_o=1 from T+7.
   - Required: frame_cnt_o=5 in DONE; holding yumi_i=0 for 10 cycles keeps v_o=1.
   - Required: yumi_i=1 -> IDLE next cycle.
3. Zero length: game_len_i=0 -> update_o one cycle, en_o never asserted, v_o at T+2.
4. Boundary: game_len_i=max_game_length_p (1000) -> exactly 1000 en_o cycles, frame_cnt_o=1000. game_len_i=1023 -> saturates to 1000 en_o cycles.
5. Interference:
   - Stimulus: v_i=1 held continuously through RUN and DONE with a different game_len_i.
   - Required: no restart, en_o count unchanged, second game accepted only one cycle after yumi_i.
   - Stimulus: reset_i during RUN at frame 3 of 8.
   - Required: IDLE next cycle, no v_o.
6. (BSG_CGOL_CTRL_PAUSE_EN) Pause:
   - Stimulus: game_len_i=6, pause_i=1 for 4 cycles after frame 2.
   - Required: en_o low during the pause, total en_o cycles=6, v_o delayed by 4 cycles vs. the unpaused run.
